aes_uart_bridge: RTL and testbench

Framing stage between the byte-wide UART and the 128-bit AES core. It assembles 32 received bytes into a key and a plaintext block, and starts the core with a single-cycle pulse. It captures the ciphertext when the core signals done, then serialises the 16 ciphertext bytes back to the UART transmitter. Only one frame is in flight at a time; bytes that arrive while the bridge is not receiving are dropped and counted.

---
 rtl/aes_bridge_pkg.sv | 25 ++
 rtl/aes_tx_serializer.sv | 105 ++++++++++
 rtl/aes_uart_bridge.sv | 175 +++++++++++++++++
 tb/tb_aes_uart_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_bridge_pkg.sv
// ---------------------------------------------------------------------------
// aes_bridge_pkg
//   Shared types and defaults for the UART <-> AES framing bridge.
//   - state_t      : bridge state encoding (RX and TX phases)
//   - block_t      : one 128-bit AES block (key, plaintext or ciphertext)
//   - BLOCK_BYTES_DEFAULT : bytes per key and per data block
// ---------------------------------------------------------------------------
package aes_bridge_pkg;

    localparam int BLOCK_BYTES_DEFAULT = 16;
    localparam int BLOCK_BITS          = 128;

    typedef logic [BLOCK_BITS-1:0] block_t;

    typedef enum logic [2:0] {
        RX_KEY       = 3'd0,
        RX_PT        = 3'd1,
        START        = 3'd2,
        WAIT_CORE    = 3'd3,
        TX_SEND      = 3'd4,
        TX_WAIT_LOW  = 3'd5,
        TX_WAIT_HIGH = 3'd6
    } state_t;

endpackage

// File: rtl/aes_tx_serializer.sv
// ---------------------------------------------------------------------------
// aes_tx_serializer
//   Sends a 128-bit block to the UART transmitter one byte at a time,
//   most significant byte first, using the tx_ready level handshake.
//
//   Ports
//     CLK, RST      : clock, asynchronous active-high reset
//     load_i        : one-cycle strobe, latch load_data_i and start sending
//     load_data_i   : block to send
//     tx_ready_i    : UART transmitter idle (level)
//     tx_data_o     : byte being sent, held until the next send request
//     tx_enable_o   : one-cycle send request
//     ser_done_o    : one-cycle pulse after the last byte has been accepted
// ---------------------------------------------------------------------------
module aes_tx_serializer
    import aes_bridge_pkg::*;
#(
    parameter int BLOCK_BYTES = BLOCK_BYTES_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load_i,
    input  block_t     load_data_i,
    input  logic       tx_ready_i,
    output logic [7:0] tx_data_o,
    output logic       tx_enable_o,
    output logic       ser_done_o
);

    localparam int               CNT_W    = $clog2(BLOCK_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES);

    state_t           state_q;
    logic             active_q;
    block_t           shift_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       tx_data_q;
    logic             tx_enable_q;
    logic             ser_done_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= TX_SEND;
            active_q    <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
            ser_done_q  <= 1'b0;
        end else begin
            tx_enable_q <= 1'b0;
            ser_done_q  <= 1'b0;
            if (load_i) begin
                shift_q  <= load_data_i;
                cnt_q    <= '0;
                active_q <= 1'b1;
                // Issue the first request straight from the load so the
                // byte leaves one cycle after core_done when the UART is idle.
                if (tx_ready_i) begin
                    tx_enable_q <= 1'b1;
                    tx_data_q   <= load_data_i[BLOCK_BITS-1 -: 8];
                    state_q     <= TX_WAIT_LOW;
                end else begin
                    state_q     <= TX_SEND;
                end
            end else if (active_q) begin
                unique case (state_q)
                    TX_SEND: begin
                        if (tx_ready_i) begin
                            tx_enable_q <= 1'b1;
                            tx_data_q   <= shift_q[BLOCK_BITS-1 -: 8];
                            state_q     <= TX_WAIT_LOW;
                        end
                    end
                    TX_WAIT_LOW: begin
                        // UART has taken the byte once it reports busy.
                        if (!tx_ready_i) begin
                            shift_q <= {shift_q[BLOCK_BITS-9:0], 8'h00};
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= TX_WAIT_HIGH;
                        end
                    end
                    TX_WAIT_HIGH: begin
                        if (tx_ready_i) begin
                            state_q <= TX_SEND;
                            if (cnt_q == CNT_LAST) begin
                                cnt_q      <= '0;
                                active_q   <= 1'b0;
                                ser_done_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= TX_SEND;
                endcase
            end
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_enable_o = tx_enable_q;
    assign ser_done_o  = ser_done_q;

endmodule

// File: rtl/aes_uart_bridge.sv
// ---------------------------------------------------------------------------
// aes_uart_bridge
//   Framing stage between a byte-wide UART and a 128-bit AES core.
//   Collects 16 key bytes then 16 plaintext bytes, pulses core_start,
//   captures the ciphertext on core_done and streams it back to the UART.
//   Bytes arriving outside the receive phase are dropped and counted.
//
//   Ports
//     CLK, RST            : clock, asynchronous active-high reset
//     rx_ready, rx_data   : received-byte strobe and data
//     tx_ready            : UART transmitter idle (level)
//     tx_data, tx_enable  : byte to send and one-cycle send request
//     core_key, core_pt   : key / plaintext, byte 0 in bits [127:120]
//     core_start          : one-cycle start pulse to the core
//     core_done, core_ct  : ciphertext strobe and data from the core
//     busy                : high in every state except RX_KEY
//     drop_cnt            : saturating count of dropped bytes
//
//   Build option
//     AES_BRIDGE_TIMEOUT_EN : when defined, a partial frame idle for
//                             TIMEOUT_CYCLES cycles is discarded.
// ---------------------------------------------------------------------------
module aes_uart_bridge
    import aes_bridge_pkg::*;
#(
    parameter int BLOCK_BYTES    = BLOCK_BYTES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_enable,
    output block_t     core_key,
    output block_t     core_pt,
    output logic       core_start,
    input  logic       core_done,
    input  block_t     core_ct,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam int                BCNT_W    = $clog2(BLOCK_BYTES);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLOCK_BYTES - 1);

    state_t            state_q;
    logic [BCNT_W-1:0] byte_cnt_q;
    block_t            key_q;
    block_t            pt_q;
    logic              core_start_q;
    logic [7:0]        drop_cnt_q;

    logic rx_window;
    logic accept;
    logic drop;
    logic ser_load;
    logic ser_done;
    logic timeout_hit;

    assign rx_window = (state_q == RX_KEY) || (state_q == RX_PT);
    assign accept    = rx_ready && rx_window;
    assign drop      = rx_ready && !rx_window;
    assign ser_load  = (state_q == WAIT_CORE) && core_done;

`ifdef AES_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            partial;

    assign partial = ((state_q == RX_KEY) && (byte_cnt_q != '0)) || (state_q == RX_PT);
    // A byte in the expiry cycle is accepted instead of timing out.
    assign timeout_hit = partial && !accept && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt_q <= '0;
        end else if (accept || !partial || timeout_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= RX_KEY;
            byte_cnt_q   <= '0;
            key_q        <= '0;
            pt_q         <= '0;
            core_start_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            core_start_q <= 1'b0;

            if (drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end

            unique case (state_q)
                RX_KEY: begin
                    if (accept) begin
                        key_q <= {key_q[BLOCK_BITS-9:0], rx_data};
                        if (byte_cnt_q == BCNT_LAST) begin
                            byte_cnt_q <= '0;
                            state_q    <= RX_PT;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        byte_cnt_q <= '0;
                    end
                end
                RX_PT: begin
                    if (accept) begin
                        pt_q <= {pt_q[BLOCK_BITS-9:0], rx_data};
                        if (byte_cnt_q == BCNT_LAST) begin
                            byte_cnt_q   <= '0;
                            core_start_q <= 1'b1;
                            state_q      <= START;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        byte_cnt_q <= '0;
                        state_q    <= RX_KEY;
                    end
                end
                START: begin
                    state_q <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_done) begin
                        state_q <= TX_SEND;
                    end
                end
                // The serializer owns the TX handshake sub-states; the bridge
                // only waits here for it to finish.
                TX_SEND, TX_WAIT_LOW, TX_WAIT_HIGH: begin
                    if (ser_done) begin
                        state_q <= RX_KEY;
                    end
                end
                default: state_q <= RX_KEY;
            endcase
        end
    end

    aes_tx_serializer #(
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_tx_serializer (
        .CLK         (CLK),
        .RST         (RST),
        .load_i      (ser_load),
        .load_data_i (core_ct),
        .tx_ready_i  (tx_ready),
        .tx_data_o   (tx_data),
        .tx_enable_o (tx_enable),
        .ser_done_o  (ser_done)
    );

    assign core_key   = key_q;
    assign core_pt    = pt_q;
    assign core_start = core_start_q;
    assign busy       = (state_q != RX_KEY);
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_aes_uart_bridge.sv
// ---------------------------------------------------------------------------
// tb_aes_uart_bridge
//   Directed bench for aes_uart_bridge: a table of frames with hand-known
//   key / plaintext / ciphertext, plus sequences for dropped bytes, drop
//   saturation, reset during transmit and partial-frame handling.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_aes_uart_bridge;
    import aes_bridge_pkg::*;

    localparam int TO_CYCLES = 100;

    logic       CLK       = 1'b0;
    logic       RST       = 1'b1;
    logic       rx_ready  = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       tx_ready  = 1'b1;
    logic       core_done = 1'b0;
    block_t     cur_ct    = '0;
    logic [7:0] tx_data;
    logic       tx_enable;
    block_t     core_key;
    block_t     core_pt;
    logic       core_start;
    logic       busy;
    logic [7:0] drop_cnt;

    aes_uart_bridge #(
        .BLOCK_BYTES    (16),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .core_key   (core_key),
        .core_pt    (core_pt),
        .core_start (core_start),
        .core_done  (core_done),
        .core_ct    (cur_ct),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- AES core model: returns cur_ct after core_delay cycles
    int     core_delay = 3;
    int     start_cnt  = 0;
    int     done_cyc   = 0;
    block_t seen_key   = '0;
    block_t seen_pt    = '0;

    always begin
        @(negedge CLK);
        if (core_start === 1'b1) begin
            start_cnt++;
            seen_key = core_key;
            seen_pt  = core_pt;
            repeat (core_delay) @(negedge CLK);
            core_done = 1'b1;
            done_cyc  = cyc;
            @(negedge CLK);
            core_done = 1'b0;
        end
    end

    // ---------------- UART transmitter model: busy for low_cycles per byte
    int         low_cycles   = 2;
    logic [7:0] tx_q[$];
    logic [7:0] held_byte    = 8'h00;
    int         first_en_cyc = 0;
    int         unstable     = 0;
    int         bad_en       = 0;

    always begin
        @(negedge CLK);
        if (tx_enable === 1'b1) begin
            if (tx_q.size() == 0) first_en_cyc = cyc;
            tx_q.push_back(tx_data);
            held_byte = tx_data;
            @(negedge CLK);
            if (!RST && tx_enable !== 1'b0) unstable++;
            tx_ready = 1'b0;
            repeat (low_cycles) begin
                @(negedge CLK);
                if (!RST && (tx_data !== held_byte || tx_enable !== 1'b0)) unstable++;
            end
            tx_ready = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (tx_enable === 1'b1 && tx_ready !== 1'b1) bad_en++;
    end

    // ---------------- stimulus helpers (called at a falling edge)
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge CLK);
        rx_ready = 1'b0;
    endtask

    task automatic send_block(input block_t blk);
        for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8]);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy !== 1'b0 || tx_ready !== 1'b1) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check({tag, " idle_within_budget"}, busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_enable"},  tx_enable,  1'b0);
        check({tag, " tx_data"},    tx_data,    8'h00);
        check({tag, " core_start"}, core_start, 1'b0);
        check({tag, " busy"},       busy,       1'b0);
        check({tag, " drop_cnt"},   drop_cnt,   8'h00);
        check({tag, " core_key"},   core_key,   128'h0);
        check({tag, " core_pt"},    core_pt,    128'h0);
    endtask

    // Full frame: key (optionally paused `gap` cycles after its 5th byte),
    // plaintext, optional dropped bytes while the core runs, then checks.
    task automatic run_frame(input string tag, input block_t key, input block_t pt,
                             input block_t ct, input int low, input int gap, input int drops);
        block_t got = '0;
        tx_q.delete();
        start_cnt  = 0;
        unstable   = 0;
        bad_en     = 0;
        cur_ct     = ct;
        low_cycles = low;
        for (int i = 0; i < 16; i++) begin
            send_byte(key[127-8*i -: 8]);
            if (i == 4 && gap > 0) repeat (gap) @(negedge CLK);
        end
        for (int i = 0; i < 16; i++) send_byte(pt[127-8*i -: 8]);
        check({tag, " start_cycle_after_last_byte"}, core_start, 1'b1);
        @(negedge CLK);
        check({tag, " start_single_cycle"}, core_start, 1'b0);
        for (int i = 0; i < drops; i++) send_byte(8'hD0 + 8'(i));
        wait_idle(tag, 20000);
        for (int i = 0; i < tx_q.size() && i < 16; i++) got = {got[119:0], tx_q[i]};
        check({tag, " start_count"}, start_cnt, 1);
        check({tag, " core_key"},    seen_key,  key);
        check({tag, " core_pt"},     seen_pt,   pt);
        check({tag, " tx_count"},    tx_q.size(), 16);
        check({tag, " tx_bytes"},    got,       ct);
        check({tag, " done_to_tx_latency"}, first_en_cyc - done_cyc, 1);
        check({tag, " tx_en_while_busy"},   bad_en,   0);
        check({tag, " tx_data_unstable"},   unstable, 0);
    endtask

    typedef struct {
        string  name;
        block_t key;
        block_t pt;
        block_t ct;
        int     low;
    } vec_t;

    vec_t vecs[3];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{"fips_c1",   128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2};
        vecs[1] = '{"fips_b",    128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 1};
        vecs[2] = '{"slow_uart", 128'hffffffffffffffffffffffffffffffff,
                    128'h00000000000000000000000000000000,
                    128'h0123456789abcdeffedcba9876543210, 500};

        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);

        for (int v = 0; v < 3; v++) begin
            run_frame(vecs[v].name, vecs[v].key, vecs[v].pt, vecs[v].ct, vecs[v].low, 0, 0);
        end
        check("no_drops_yet", drop_cnt, 8'd0);

        // Three bytes during WAIT_CORE are dropped; ciphertext unaffected.
        core_delay = 20;
        run_frame("drops", vecs[0].key, vecs[0].pt, vecs[0].ct, 2, 0, 3);
        check("drop_cnt_3", drop_cnt, 8'd3);
        run_frame("after_drops", vecs[1].key, vecs[1].pt, vecs[1].ct, 2, 0, 0);
        check("drop_cnt_held", drop_cnt, 8'd3);

        // Counter saturates at 255.
        core_delay = 300;
        run_frame("saturate", vecs[1].key, vecs[1].pt, vecs[1].ct, 1, 0, 260);
        check("drop_cnt_sat", drop_cnt, 8'd255);

        // Reset after the 4th transmitted byte.
        core_delay = 3;
        tx_q.delete();
        cur_ct     = vecs[0].ct;
        low_cycles = 4;
        send_block(vecs[0].key);
        send_block(vecs[0].pt);
        n = 0;
        while (tx_q.size() < 4 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("rst_four_bytes_sent", tx_q.size(), 4);
        check("rst_first_byte", tx_q[0], 8'h69);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outputs("mid_tx_reset");
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("rst_no_more_tx", tx_q.size(), 4);
        check("rst_back_to_rx_key", busy, 1'b0);
        run_frame("post_reset", vecs[0].key, vecs[0].pt, vecs[0].ct, 2, 0, 0);

`ifdef AES_BRIDGE_TIMEOUT_EN
        // Five stray bytes then TO_CYCLES idle cycles: discarded.
        for (int i = 0; i < 5; i++) send_byte(8'h5A);
        repeat (TO_CYCLES) @(negedge CLK);
        run_frame("after_timeout", vecs[1].key, vecs[1].pt, vecs[1].ct, 2, 0, 0);
        // Next byte lands in the last cycle before expiry: frame continues.
        run_frame("byte_at_limit", 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf,
                  128'h112233445566778899aabbccddeeff00,
                  128'hfedcba98765432100123456789abcdef, 2, TO_CYCLES - 1, 0);
`else
        // Without the timeout a long pause keeps the partial frame.
        run_frame("long_pause", 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf,
                  128'h112233445566778899aabbccddeeff00,
                  128'hfedcba98765432100123456789abcdef, 2, 150, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
